// File: rtl/strobe_sequencer.sv
// Multi-channel trigger-to-strobe sequencer: sync, divide, rate-gate, delay/stretch.
// Optional period measurement outputs under STROBE_SEQ_PERIOD_MEAS_EN.
module strobe_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig_in,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        div_ratio,
  input  logic [CNT_W-1:0]        min_period,
  input  logic [NUM_CH*CNT_W-1:0] ch_delay,
  input  logic [NUM_CH*CNT_W-1:0] ch_width,
  input  logic                    overrun_clr,
  output logic [NUM_CH-1:0]       fire_out,
  output logic                    busy,
  output logic                    overrun
`ifdef STROBE_SEQ_PERIOD_MEAS_EN
  ,
  output logic [CNT_W-1:0]        period_out,
  output logic                    period_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    PULSE
  } ch_state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   trig_edge;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] ratio_m1;
  logic             cand;

  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             armed_q, armed_d;
  logic             gate_ok, accept, start;

  logic             ovr_q, ovr_d;
  logic             busy_now;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  logic [CNT_W-1:0] wid_q   [NUM_CH];
  logic [CNT_W-1:0] wid_d   [NUM_CH];
  logic [CNT_W-1:0] cfg_dly, cfg_wid;
  logic [NUM_CH-1:0] fire_q, fire_d;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], trig_in};
    prev_d    = sync_q[SYNC_STAGES-1];
    trig_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  // >= rather than == so a ratio lowered below the count fires next edge
  always_comb begin
    ratio_m1  = (div_ratio == '0) ? '0 : div_ratio - DIV_W'(1);
    div_cnt_d = div_cnt_q;
    cand      = 1'b0;
    if (trig_edge && enable) begin
      if (div_cnt_q >= ratio_m1) begin
        div_cnt_d = '0;
        cand      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    busy_now = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_now = busy_now | (state_q[i] != IDLE);
    end
  end

  always_comb begin
    gate_ok = armed_q || (min_period == '0) ||
              (period_cnt_q >= min_period - CNT_W'(1));
    accept  = cand && gate_ok;
    start   = accept && !busy_now;
    armed_d = armed_q;
    period_cnt_d = (&period_cnt_q) ? period_cnt_q
                                   : period_cnt_q + CNT_W'(1);
    if (accept) begin
      period_cnt_d = '0;
      armed_d      = 1'b0;
    end
    ovr_d = (accept && busy_now) || (ovr_q && !overrun_clr);
  end

  always_comb begin
    cfg_dly = '0;
    cfg_wid = '0;
    fire_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      wid_d[i]   = wid_q[i];
      cfg_dly    = ch_delay[i*CNT_W +: CNT_W];
      cfg_wid    = ch_width[i*CNT_W +: CNT_W];
      unique case (state_q[i])
        IDLE: begin
          if (start && cfg_wid != '0) begin
            wid_d[i] = cfg_wid;
            if (cfg_dly == '0) begin
              state_d[i] = PULSE;
              cnt_d[i]   = cfg_wid - CNT_W'(1);
            end else begin
              state_d[i] = DELAY;
              cnt_d[i]   = cfg_dly - CNT_W'(1);
            end
          end
        end
        DELAY: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = PULSE;
            cnt_d[i]   = wid_q[i] - CNT_W'(1);
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
      fire_d[i] = (state_d[i] == PULSE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      div_cnt_q    <= '0;
      period_cnt_q <= '0;
      armed_q      <= 1'b1;
      ovr_q        <= 1'b0;
      fire_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        wid_q[i]   <= '0;
      end
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      div_cnt_q    <= div_cnt_d;
      period_cnt_q <= period_cnt_d;
      armed_q      <= armed_d;
      ovr_q        <= ovr_d;
      fire_q       <= fire_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        wid_q[i]   <= wid_d[i];
      end
    end
  end

  assign fire_out = fire_q;
  assign busy     = busy_now;
  assign overrun  = ovr_q;

`ifdef STROBE_SEQ_PERIOD_MEAS_EN
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [CNT_W-1:0] pout_q, pout_d;
  logic             seen_q, seen_d;
  logic             pval_q, pval_d;

  // first edge only starts the count; later edges report it
  always_comb begin
    meas_cnt_d = (&meas_cnt_q) ? meas_cnt_q : meas_cnt_q + CNT_W'(1);
    pout_d     = pout_q;
    seen_d     = seen_q;
    pval_d     = 1'b0;
    if (trig_edge) begin
      meas_cnt_d = CNT_W'(1);
      seen_d     = 1'b1;
      if (seen_q) begin
        pout_d = meas_cnt_q;
        pval_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meas_cnt_q <= '0;
      pout_q     <= '0;
      seen_q     <= 1'b0;
      pval_q     <= 1'b0;
    end else begin
      meas_cnt_q <= meas_cnt_d;
      pout_q     <= pout_d;
      seen_q     <= seen_d;
      pval_q     <= pval_d;
    end
  end

  assign period_out   = pout_q;
  assign period_valid = pval_q;
`endif

endmodule

// File: tb/tb_strobe_sequencer.sv
// Self-checking bench for strobe_sequencer against a window-based reference model.
// Define STROBE_SEQ_PERIOD_MEAS_EN to also check the period measurement outputs.
module tb_strobe_sequencer;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int DIV_W  = 8;
  localparam int SS     = 2;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    trig_in = 1'b0;
  logic                    enable = 1'b1;
  logic [DIV_W-1:0]        div_ratio = 8'd1;
  logic [CNT_W-1:0]        min_period = '0;
  logic [NUM_CH*CNT_W-1:0] ch_delay = '0;
  logic [NUM_CH*CNT_W-1:0] ch_width = '0;
  logic                    overrun_clr = 1'b0;
  logic [NUM_CH-1:0]       fire_out;
  logic                    busy;
  logic                    overrun;
`ifdef STROBE_SEQ_PERIOD_MEAS_EN
  logic [CNT_W-1:0]        period_out;
  logic                    period_valid;
`endif

  strobe_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W),
    .DIV_W(DIV_W), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .trig_in(trig_in),
    .enable(enable), .div_ratio(div_ratio),
    .min_period(min_period), .ch_delay(ch_delay),
    .ch_width(ch_width), .overrun_clr(overrun_clr),
    .fire_out(fire_out), .busy(busy), .overrun(overrun)
`ifdef STROBE_SEQ_PERIOD_MEAS_EN
    , .period_out(period_out), .period_valid(period_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Model: each accepted trigger opens a busy window and a fire window
  // per channel, expressed in absolute clock-edge numbers.
  longint cyc = 0;
  longint pend[$];
  bit     last_raw;
  int     dc;
  bit     armed;
  longint last_acc;
  bit     ov;
  longint b_lo [NUM_CH];
  longint b_hi [NUM_CH];
  longint f_lo [NUM_CH];
  longint f_hi [NUM_CH];
  bit     m_seen;
  longint m_last;
  longint e_pout;
  bit     e_pval;

  always @(posedge clk) begin
    bit     set, cand, bprev;
    longint d, w, r;
    cyc++;
    if (reset) begin
      last_raw = 0; pend.delete(); dc = 0; armed = 1;
      ov = 0; last_acc = 0; m_seen = 0; e_pout = 0; e_pval = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        b_lo[i] = 0; b_hi[i] = 0; f_lo[i] = 0; f_hi[i] = 0;
      end
    end else begin
      e_pval = 0;
      set = 0;
      if (trig_in && !last_raw) pend.push_back(cyc + SS);
      last_raw = trig_in;
      if (pend.size() > 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        if (m_seen) begin
          e_pout = cyc - m_last;
          e_pval = 1;
        end
        m_seen = 1;
        m_last = cyc;
        cand = 0;
        if (enable) begin
          r = (div_ratio == 0) ? 1 : div_ratio;
          if (dc + 1 >= r) begin dc = 0; cand = 1; end
          else dc++;
        end
        if (cand && (armed || min_period == 0 ||
                     cyc - last_acc >= longint'(min_period))) begin
          armed = 0;
          last_acc = cyc;
          bprev = 0;
          for (int i = 0; i < NUM_CH; i++)
            if (b_lo[i] <= cyc - 1 && cyc - 1 < b_hi[i]) bprev = 1;
          if (bprev) set = 1;
          else begin
            for (int i = 0; i < NUM_CH; i++) begin
              d = ch_delay[i*CNT_W +: CNT_W];
              w = ch_width[i*CNT_W +: CNT_W];
              if (w != 0) begin
                b_lo[i] = cyc; b_hi[i] = cyc + d + w;
                f_lo[i] = cyc + d; f_hi[i] = cyc + d + w;
              end
            end
          end
        end
      end
      ov = set | (ov & !overrun_clr);
    end
  end

  task automatic step();
    bit eb;
    @(negedge clk);
    eb = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("fire%0d", i), longint'(fire_out[i]),
          longint'(f_lo[i] <= cyc && cyc < f_hi[i]));
      if (b_lo[i] <= cyc && cyc < b_hi[i]) eb = 1;
    end
    chk("busy", longint'(busy), longint'(eb));
    chk("overrun", longint'(overrun), longint'(ov));
`ifdef STROBE_SEQ_PERIOD_MEAS_EN
    chk("pval", longint'(period_valid), longint'(e_pval));
    chk("pout", longint'(period_out), e_pout);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int len, input int gap);
    trig_in = 1'b1;
    run(len);
    trig_in = 1'b0;
    run(gap);
  endtask

  task automatic cfg(input int d0, input int d1, input int w0, input int w1);
    ch_delay = {CNT_W'(d1), CNT_W'(d0)};
    ch_width = {CNT_W'(w1), CNT_W'(w0)};
  endtask

  initial begin
    run(3);
    reset = 1'b0;
    run(2);

    // basic delay/width, long trigger pulse
    cfg(0, 10, 3, 5);
    pulse(7, 30);

    // divider by 3, then 0 acting as 1
    div_ratio = 8'd3;
    repeat (7) pulse(2, 48);
    div_ratio = 8'd0;
    repeat (3) pulse(1, 49);
    div_ratio = 8'd1;

    // rate gate
    reset = 1'b1; run(1); reset = 1'b0;
    min_period = 32'd100;
    cfg(0, 0, 2, 2);
    repeat (6) pulse(1, 59);
    min_period = '0;

    // overrun, clear, and set/clear collision
    cfg(20, 20, 20, 20);
    pulse(1, 9);
    pulse(1, 50);
    overrun_clr = 1'b1; run(1); overrun_clr = 1'b0;
    run(2);
    pulse(1, 9);
    trig_in = 1'b1; run(1);
    trig_in = 1'b0; run(1);
    overrun_clr = 1'b1; run(1);
    overrun_clr = 1'b0; run(50);

    // reset mid-PULSE on ch0 while ch1 is in DELAY
    cfg(0, 30, 10, 5);
    pulse(1, 6);
    reset = 1'b1; run(1); reset = 1'b0;
    run(3);
    pulse(1, 45);
    // reset mid-DELAY
    pulse(1, 15);
    reset = 1'b1; run(1); reset = 1'b0;
    pulse(1, 45);

    // enable drop mid-sequence
    pulse(1, 5);
    enable = 1'b0;
    pulse(1, 45);
    enable = 1'b1;

`ifdef STROBE_SEQ_PERIOD_MEAS_EN
    cfg(0, 0, 1, 1);
    repeat (5) pulse(1, 479);
`endif

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(99) < 15) trig_in = ~trig_in;
      if ($urandom_range(99) < 3) begin
        cfg($urandom_range(15), $urandom_range(15),
            $urandom_range(12), $urandom_range(12));
        div_ratio  = DIV_W'($urandom_range(3));
        min_period = CNT_W'($urandom_range(3) == 0 ? 0 : $urandom_range(40));
      end
      enable      = ($urandom_range(99) < 90);
      overrun_clr = ($urandom_range(99) < 5);
      reset       = ($urandom_range(999) < 4);
      step();
    end
    reset = 1'b0;
    overrun_clr = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/strobe_sequencer.md
Name: strobe_sequencer

Overview:
- Multi-channel trigger-to-strobe sequencer for the propeller/camera strobe rig. Generalises the single delay-and-stretch strobe path to NUM_CH independent channels.
- Takes one asynchronous trigger input (laser/tach pulse), synchronises it, edge-detects it and divides it by a programmable ratio. Applies a minimum-period rate gate, then fires every channel after its own delay for its own width.
- Sits between the GPIO trigger pin and the LED/camera output pins.

Parameters:
- NUM_CH, 2, number of strobe output channels (1..8).
- CNT_W, 32, width of the delay, width and period counters.
- DIV_W, 8, width of the trigger divider ratio.
- SYNC_STAGES, 2, synchroniser flop count on trig_in (>=2).

Ports:
- clk  in  1  system clock (48 MHz).
- reset  in  1  synchronous, active-high reset.
- trig_in  in  1  asynchronous trigger pulse, any length.
- enable  in  1  accept triggers when high.
- div_ratio  in  DIV_W  fire on every Nth qualified edge; 0 is treated as 1.
- min_period  in  CNT_W  minimum clk cycles between accepted triggers; 0 disables the gate.
- ch_delay  in  NUM_CH*CNT_W  per-channel delay in cycles; channel i occupies bits [i*CNT_W +: CNT_W].
- ch_width  in  NUM_CH*CNT_W  per-channel pulse width in cycles; 0 disables the channel.
- fire_out  out  NUM_CH  registered strobe outputs.
- busy  out  1  OR of all channels not IDLE.
- overrun  out  1  sticky; set when a trigger is dropped because a channel is busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset: fire_out=0, busy=0, overrun=0. Divider count=0, all channels IDLE, period counter=0, rate gate armed, synchroniser and edge-history flops=0.
- Sync/edge: trig_in passes through SYNC_STAGES flops. edge = sync & ~sync_prev, one cycle per rising edge regardless of input pulse length.
- Divider:
  - On edge with enable=1: if div_cnt == max(div_ratio,1)-1, then div_cnt<=0 and the edge is a candidate; else div_cnt<=div_cnt+1.
  - Edges with enable=0 are not counted.
  - If div_ratio is reduced below div_cnt+1, the next edge is a candidate and div_cnt returns to 0.
- Rate gate:
  - Period counter increments every cycle and saturates at all ones.
  - A candidate is accepted if the gate is armed or period_cnt >= min_period-1; this gives exactly min_period cycles between accepts.
  - On accept: period_cnt<=0 and the gate is disarmed. A rejected candidate is dropped silently; it does not set overrun and does not change the divider state.
- Overrun: an accepted trigger while any enabled channel (ch_width != 0) is not IDLE is dropped and sets overrun. Channels keep their current sequence. overrun_clr in the same cycle as a new overrun: set wins.
- Channel FSM, one per channel, states IDLE, DELAY, PULSE:
  - IDLE -> on accept with width!=0: latch delay/width into channel registers. If delay==0 go to PULSE with cnt<=width-1; else go to DELAY with cnt<=delay-1.
  - DELAY: if cnt==0 go to PULSE with cnt<=width-1; else cnt--.
  - PULSE: fire_out[i]=1. If cnt==0 go to IDLE; else cnt--.
  - Configuration inputs are sampled only at accept. Changes mid-sequence take effect on the next trigger.
  - Channels with width==0 stay IDLE and never assert.
- Latency: E0 is the first clk edge sampling trig_in high. fire_out[i] goes high after edge E(SYNC_STAGES+delay_i) and stays high exactly width_i cycles. No gaps; back-to-back sequences are prevented by the overrun rule.
- enable deasserted mid-sequence: running channels complete; no new accepts.
- reset mid-sequence: all outputs drop low on the next edge; in-flight sequences are discarded.

Optional Feature:
- Macro STROBE_SEQ_PERIOD_MEAS_EN.
- Defined: adds outputs period_out [CNT_W] and period_valid [1].
  - A separate counter measures clk cycles between consecutive synced edges, independent of enable, divider and gate.
  - On each edge after the first since reset: period_out<=count, period_valid pulses high one cycle, count<=1. The counter saturates at all ones.
  - Reset values: period_out=0, period_valid=0.
- Undefined: these ports and the counter are absent; the rest of the behaviour is identical.

Test Plan:
- NUM_CH=2, div_ratio=1, min_period=0, delay={0,10}, width={3,5}; trig_in high at E0 -> fire_out[0] high E2..E4, fire_out[1] high E12..E16, busy low after E17.
- div_ratio=3, 7 trig_in pulses spaced 50 cycles -> sequences fire on pulses 3 and 6 only; div_ratio=0 behaves as 1.
- min_period=100, candidates spaced 60 cycles, delay=0, width=2 -> accepts on candidates 1, 3, 5; no overrun.
- delay=20, width=20, second trigger 10 cycles after the first -> single 20-cycle pulse, overrun=1; overrun_clr -> 0; set and clear in the same cycle -> stays 1.
- reset asserted mid-PULSE and mid-DELAY -> fire_out=0 and busy=0 after the next edge; the next trigger fires normally with the gate armed.
- STROBE_SEQ_PERIOD_MEAS_EN defined, edges every 480 cycles -> period_valid pulses from the 2nd edge on, with period_out=480.
